// File: rtl/processor.sv
// Single-cycle register-to-register datapath: 32x32 register file, decoder and ALU.
// Define PROCESSOR_EXT_OPS_EN to add the XOR, SLT and SLL opcodes.
module processor #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
`ifdef PROCESSOR_EXT_OPS_EN
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_SLL = 6'b000110;
`endif

  logic [5:0]            opcode_s;
  logic [4:0]            rs_s;
  logic [4:0]            rt_s;
  logic [4:0]            rd_s;
  logic [DATA_WIDTH-1:0] rs_val_s;
  logic [DATA_WIDTH-1:0] rt_val_s;
  logic [DATA_WIDTH-1:0] alu_s;
  logic                  valid_op_s;
  logic                  we_s;
  logic                  unused_s;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_d;

  assign opcode_s = instruction[31:26];
  assign rs_s     = instruction[25:21];
  assign rt_s     = instruction[20:16];
  assign rd_s     = instruction[15:11];
  assign unused_s = ^instruction[10:0];

`ifdef PROCESSOR_EXT_OPS_EN
  logic [4:0] shamt_s;
  assign shamt_s = instruction[10:6];
`endif

  // Register 0 is hard-wired to zero on the read side as well as never being written.
  assign rs_val_s = (rs_s == 5'd0) ? {DATA_WIDTH{1'b0}} : regs_q[rs_s];
  assign rt_val_s = (rt_s == 5'd0) ? {DATA_WIDTH{1'b0}} : regs_q[rt_s];

  // Opcode decode and ALU
  always_comb begin
    alu_s      = {DATA_WIDTH{1'b0}};
    valid_op_s = 1'b0;
    case (opcode_s)
      OP_ADD: begin alu_s = rs_val_s + rt_val_s; valid_op_s = 1'b1; end
      OP_SUB: begin alu_s = rs_val_s - rt_val_s; valid_op_s = 1'b1; end
      OP_AND: begin alu_s = rs_val_s & rt_val_s; valid_op_s = 1'b1; end
      OP_OR:  begin alu_s = rs_val_s | rt_val_s; valid_op_s = 1'b1; end
`ifdef PROCESSOR_EXT_OPS_EN
      OP_XOR: begin alu_s = rs_val_s ^ rt_val_s; valid_op_s = 1'b1; end
      OP_SLT: begin
        alu_s      = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs_val_s) < $signed(rt_val_s))};
        valid_op_s = 1'b1;
      end
      OP_SLL: begin alu_s = rt_val_s << shamt_s; valid_op_s = 1'b1; end
`endif
      default: begin
        alu_s      = {DATA_WIDTH{1'b0}};
        valid_op_s = 1'b0;
      end
    endcase
  end

  assign we_s     = valid_op_s && (rd_s != 5'd0);
  assign result_d = alu_s;

  // Next-state register file: writeback lands on the same edge that captures result
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we_s) begin
      regs_d[rd_s] = alu_s;
    end else begin
      regs_d[rd_s] = regs_q[rd_s];
    end
  end

  // State registers; reset loads reg[i] = i
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= DATA_WIDTH'(i);
      end
    end else begin
      result_q <= result_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed plan vectors plus random
// instructions checked against an architectural register-file model.
module tb_processor;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] result;

  int          n_checks;
  int          n_fail;
  logic [31:0] mregs [32];
  logic [31:0] exp_result;

  localparam logic [5:0] NOP_OP = 6'b111111;

  processor dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh);
    return {op, rs, rt, rd, sh, 6'b000000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = i;
    exp_result = 32'd0;
  endtask

  // Architectural meaning of one instruction, applied to the model.
  task automatic model_exec(input logic [31:0] ins);
    int unsigned op;
    int unsigned a;
    int unsigned b;
    int          sa;
    int          sb;
    int unsigned r;
    bit          ok;
    int unsigned rd;
    op = ins[31:26];
    a  = (ins[25:21] == 5'd0) ? 0 : mregs[ins[25:21]];
    b  = (ins[20:16] == 5'd0) ? 0 : mregs[ins[20:16]];
    sa = a;
    sb = b;
    rd = ins[15:11];
    ok = 1'b1;
    r  = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
`ifdef PROCESSOR_EXT_OPS_EN
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = b << ins[10:6];
`endif
      default: begin r = 0; ok = 1'b0; end
    endcase
    exp_result = r;
    if (ok && rd != 0) mregs[rd] = r;
  endtask

  // Apply one instruction for one clock; result is sampled 1 ns after the edge.
  task automatic run(input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    model_exec(ins);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    instruction = enc(NOP_OP, 5'd0, 5'd0, 5'd0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result !== 32'd0) begin
      $display("FAIL reset_result: got %h expected %h", result, 32'd0);
      n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i < 32; i += 10) begin
      run(enc(6'b000000, i[4:0], 5'd0, 5'd0, 5'd0));
      n_checks++;
      if (result !== i) begin
        $display("FAIL reset_reg%0d: got %h expected %h", i, result, i);
        n_fail++;
      end
    end
  endtask

  task automatic test_alu_basic();
    logic [31:0] ins [5];
    logic [31:0] exp [5];
    ins[0] = enc(6'b000000, 5'd0, 5'd1, 5'd0, 5'd0); exp[0] = 32'd1;
    ins[1] = enc(6'b000000, 5'd0, 5'd0, 5'd0, 5'd0); exp[1] = 32'd0;
    ins[2] = enc(6'b000001, 5'd0, 5'd1, 5'd0, 5'd0); exp[2] = 32'hFFFFFFFF;
    ins[3] = enc(6'b000011, 5'd0, 5'd1, 5'd0, 5'd0); exp[3] = 32'd1;
    ins[4] = enc(6'b000010, 5'd3, 5'd5, 5'd0, 5'd0); exp[4] = 32'd1;
    for (int i = 0; i < 5; i++) begin
      run(ins[i]);
      n_checks++;
      if (result !== exp[i]) begin
        $display("FAIL alu_basic_%0d: got %h expected %h", i, result, exp[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_nop();
    run(enc(NOP_OP, 5'd1, 5'd2, 5'd3, 5'd0));
    n_checks++;
    if (result !== 32'd0) begin
      $display("FAIL nop_result: got %h expected %h", result, 32'd0);
      n_fail++;
    end
    run(enc(6'b000000, 5'd3, 5'd0, 5'd0, 5'd0));
    n_checks++;
    if (result !== 32'd3) begin
      $display("FAIL nop_no_write: got %h expected %h", result, 32'd3);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    run(enc(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0));
    n_checks++;
    if (result !== 32'd3) begin
      $display("FAIL chain_add1: got %h expected %h", result, 32'd3);
      n_fail++;
    end
    run(enc(6'b000000, 5'd3, 5'd3, 5'd4, 5'd0));
    n_checks++;
    if (result !== 32'd6) begin
      $display("FAIL chain_add2: got %h expected %h", result, 32'd6);
      n_fail++;
    end
    run(enc(6'b000001, 5'd0, 5'd4, 5'd5, 5'd0));
    n_checks++;
    if (result !== 32'hFFFFFFFA) begin
      $display("FAIL chain_sub: got %h expected %h", result, 32'hFFFFFFFA);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (result !== 32'd0) begin
      $display("FAIL async_reset_immediate: got %h expected %h", result, 32'd0);
      n_fail++;
    end
    model_reset();
    instruction = enc(6'b000000, 5'd1, 5'd1, 5'd7, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result !== 32'd0) begin
      $display("FAIL async_reset_hold: got %h expected %h", result, 32'd0);
      n_fail++;
    end
    @(negedge clk);
    instruction = enc(NOP_OP, 5'd0, 5'd0, 5'd0, 5'd0);
    reset       = 1'b1;
    run(enc(6'b000000, 5'd3, 5'd4, 5'd0, 5'd0));
    n_checks++;
    if (result !== 32'd7) begin
      $display("FAIL async_reset_restore: got %h expected %h", result, 32'd7);
      n_fail++;
    end
    run(enc(6'b000000, 5'd7, 5'd0, 5'd0, 5'd0));
    n_checks++;
    if (result !== 32'd7) begin
      $display("FAIL async_reset_reg7: got %h expected %h", result, 32'd7);
      n_fail++;
    end
  endtask

  task automatic test_ext_ops();
    logic [31:0] ins [3];
    logic [31:0] exp [3];
    ins[0] = enc(6'b000100, 5'd5, 5'd3, 5'd0, 5'd0);
    ins[1] = enc(6'b000101, 5'd5, 5'd3, 5'd0, 5'd0);
    ins[2] = enc(6'b000110, 5'd0, 5'd3, 5'd0, 5'd4);
`ifdef PROCESSOR_EXT_OPS_EN
    exp[0] = 32'd6; exp[1] = 32'd0; exp[2] = 32'd48;
`else
    exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      run(ins[i]);
      n_checks++;
      if (result !== exp[i]) begin
        $display("FAIL ext_op_%0d: got %h expected %h", i, result, exp[i]);
        n_fail++;
      end
    end
    // SLT is signed: reg31 - reg1 style negative value versus positive.
    run(enc(6'b000001, 5'd0, 5'd9, 5'd20, 5'd0));
    run(enc(6'b000101, 5'd20, 5'd2, 5'd21, 5'd0));
`ifdef PROCESSOR_EXT_OPS_EN
    exp[0] = 32'd1;
`else
    exp[0] = 32'd0;
`endif
    n_checks++;
    if (result !== exp[0]) begin
      $display("FAIL ext_slt_signed: got %h expected %h", result, exp[0]);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0]  op;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        8:       op = NOP_OP;
        9:       op = 6'($urandom);
        default: op = 6'($urandom_range(0, 7));
      endcase
      ins = {op, 26'($urandom)};
      run(ins);
      n_checks++;
      if (result !== exp_result) begin
        $display("FAIL random_%0d ins=%h: got %h expected %h", i, ins, result, exp_result);
        n_fail++;
      end
    end
    for (int r = 1; r < 32; r++) begin
      run(enc(6'b000011, r[4:0], 5'd0, 5'd0, 5'd0));
      n_checks++;
      if (result !== mregs[r]) begin
        $display("FAIL random_regfile_r%0d: got %h expected %h", r, result, mregs[r]);
        n_fail++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu_basic();
    test_nop();
    test_back_to_back();
    test_async_reset();
    test_ext_ops();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
